// File: rtl/tree_pkg.sv
// Shared definitions for the BST store and its in-order walker.
// Contents: key/index widths, node capacity, the "no child" pointer value,
// the stack-pointer width and the walker state encoding.
package tree_pkg;

    localparam int KEY_W = 4;               // key width
    localparam int IDX_W = 3;               // node index width
    localparam int NODES = 7;               // node capacity, also stack depth
    localparam int SP_W  = $clog2(NODES + 1);

    // Child pointer value meaning "no child".
    localparam logic [IDX_W-1:0] NULL_IDX = IDX_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DESCEND = 3'd1,
        ST_POP     = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } walk_state_e;

endpackage

// File: rtl/tree_inorder_walker_walk_stack.sv
// walk_stack: NODES-deep LIFO of node indices used by the in-order walker.
// Ports:
//   clk, rst_n   clock, async active-low reset (clears the stack pointer)
//   clear        synchronous empty; wins over push/pop in the same cycle
//   push         write push_data on top (ignored when full)
//   pop          drop the top entry (ignored when empty)
//   push_data    index to push
//   top          current top entry, combinational ('0 when empty)
//   full, empty  occupancy flags
module walk_stack
    import tree_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [IDX_W-1:0] push_data,
    output logic [IDX_W-1:0] top,
    output logic             full,
    output logic             empty
);

    logic [IDX_W-1:0] mem_q [NODES];
    logic [SP_W-1:0]  sp_q;

    assign full  = (sp_q == SP_W'(NODES));
    assign empty = (sp_q == '0);
    assign top   = empty ? '0 : mem_q[sp_q - SP_W'(1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else if (clear) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

    // NOTE: entry storage has no reset; an entry is only read below sp_q,
    // so it is always written before it can be observed.
    always_ff @(posedge clk) begin
        if (!clear && push && !full) begin
            mem_q[sp_q] <= push_data;
        end
    end

endmodule

// File: rtl/tree_inorder_walker.sv
// tree_inorder_walker: on request, walks the stored BST in-order and streams
// its keys in ascending order over a valid/ready port.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 1-cycle walk request (ignored unless idle)
//   abort                 cancel any walk; back to idle next cycle, no done
//   tree_count            nodes in the store; root is index 0
//   rd_idx                read address into the store
//   rd_key/left/right     store contents at rd_idx, same cycle
//   out_key, out_valid    emitted key and its valid
//   out_ready             consumer accepts when out_valid & out_ready
//   busy                  walk in progress
//   done                  1-cycle pulse at walk end
//   err                   stack overflow (cyclic/corrupt tree); sticky until
//                         the next accepted start
module tree_inorder_walker
    import tree_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] tree_count,
    output logic [IDX_W-1:0] rd_idx,
    input  logic [KEY_W-1:0] rd_key,
    input  logic [IDX_W-1:0] rd_left,
    input  logic [IDX_W-1:0] rd_right,
    output logic [KEY_W-1:0] out_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    walk_state_e      state_q;
    logic [IDX_W-1:0] cur_q;
    logic [KEY_W-1:0] out_key_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             cur_null;
    logic             stk_push;
    logic             stk_pop;
    logic             stk_clear;
    logic [IDX_W-1:0] stk_top;
    logic             stk_full;
    logic             stk_empty;

    // A pointer is "no child" when it is the NULL marker or beyond the store.
    assign cur_null = (cur_q == NULL_IDX) || (cur_q >= tree_count);

    // NOTE: every signal driven here gets a default first, so no latch can form.
    always_comb begin
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = abort || (state_q == ST_IDLE && start);
        rd_idx    = '0;
        case (state_q)
            ST_DESCEND: begin
                rd_idx   = cur_q;
                stk_push = !abort && !cur_null && !stk_full;
            end
            ST_POP: begin
                rd_idx  = stk_top;
                stk_pop = !abort;
            end
            default: ;
        endcase
    end

    walk_stack u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (cur_q),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            out_key_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            err_q <= 1'b0;
                            cur_q <= '0;
                            if (tree_count != '0) begin
                                busy_q  <= 1'b1;
                                state_q <= ST_DESCEND;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_DESCEND: begin
                        if (!cur_null) begin
                            if (stk_full) begin
                                // Deeper than the tree can be: the links loop.
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                cur_q <= rd_left;
                            end
                        end else if (stk_empty) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_POP;
                        end
                    end
                    ST_POP: begin
                        out_key_q   <= rd_key;
                        cur_q       <= rd_right;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_EMIT;
                    end
                    ST_EMIT: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_DESCEND;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_key   = out_key_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_tree_inorder_walker.sv
// Directed self-checking bench for tree_inorder_walker. A behavioural BST
// store answers the walker's combinational reads; expected key sequences
// and cycle counts are hand-computed constants.
module tb_tree_inorder_walker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] tree_count = 3'd0;
    logic [2:0] rd_idx;
    logic [3:0] rd_key;
    logic [2:0] rd_left;
    logic [2:0] rd_right;
    logic [3:0] out_key;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    // Store model: 8 slots so an out-of-range read address is harmless.
    logic [3:0] key_m   [8];
    logic [2:0] left_m  [8];
    logic [2:0] right_m [8];
    int         cnt;

    assign rd_key   = key_m[rd_idx];
    assign rd_left  = left_m[rd_idx];
    assign rd_right = right_m[rd_idx];

    tree_inorder_walker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .tree_count (tree_count),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .rd_left    (rd_left),
        .rd_right   (rd_right),
        .out_key    (out_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tree_clear();
        for (int i = 0; i < 8; i++) begin
            key_m[i]   = 4'd0;
            left_m[i]  = 3'd7;
            right_m[i] = 3'd7;
        end
        cnt        = 0;
        tree_count = 3'd0;
    endtask

    // Plain BST insert into the next free slot.
    task automatic tree_add(input logic [3:0] k);
        int p;
        bit placed;
        key_m[cnt]   = k;
        left_m[cnt]  = 3'd7;
        right_m[cnt] = 3'd7;
        if (cnt != 0) begin
            p = 0;
            placed = 1'b0;
            while (!placed) begin
                if (k < key_m[p]) begin
                    if (left_m[p] == 3'd7) begin
                        left_m[p] = 3'(cnt);
                        placed = 1'b1;
                    end else p = int'(left_m[p]);
                end else begin
                    if (right_m[p] == 3'd7) begin
                        right_m[p] = 3'(cnt);
                        placed = 1'b1;
                    end else p = int'(right_m[p]);
                end
            end
        end
        cnt++;
        tree_count = 3'(cnt);
    endtask

    // Results of the most recent walk.
    int got_keys [16];
    int got_n;
    int done_cnt;
    int first_valid;
    int first_done;
    bit saw_valid;
    bit saw_busy;

    // Pulse start and observe for `budget` cycles. Cycle 1 is the first cycle
    // after the edge that samples start. If stall_key appears on out_key,
    // ready is held low for 10 cycles (with a start pulse while busy).
    task automatic walk(input int stall_key, input int budget);
        bit stalled;
        stalled = 1'b0;
        got_n = 0; done_cnt = 0; first_valid = 0; first_done = 0;
        saw_valid = 1'b0; saw_busy = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && !saw_valid) first_valid = c;
            if (out_valid) saw_valid = 1'b1;
            if (busy) saw_busy = 1'b1;
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
            end
            if (out_valid && int'(out_key) == stall_key && !stalled) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                start = 1'b1;
                for (int s = 0; s < 10; s++) begin
                    @(negedge clk);
                    start = 1'b0;
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_key", int'(out_key), stall_key);
                end
                out_ready = 1'b1;
                c += 10;
            end
            if (out_valid && out_ready && got_n < 16) begin
                got_keys[got_n] = int'(out_key);
                got_n++;
            end
        end
    endtask

    task automatic check_seq(input string tag, input int exp [7], input int n);
        check({tag, "_n"}, got_n, n);
        for (int i = 0; i < n; i++) check({tag, "_key"}, got_keys[i], exp[i]);
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_err"}, int'(err), 0);
    endtask

    // Start a walk, let two keys be accepted, then cut it by abort or reset.
    task automatic cut_after2(input bit use_reset);
        int n;
        n = 0;
        out_ready = 1'b1;
        start = 1'b1;
        for (int c = 0; c < 60 && n < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_ready) n++;
        end
        check("cut_two_keys", n, 2);
        @(negedge clk);
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            check("rst_valid", int'(out_valid), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_key", int'(out_key), 0);
            check("rst_rd_idx", int'(rd_idx), 0);
        end else begin
            abort = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b0;
        check("cut_valid", int'(out_valid), 0);
        check("cut_busy", int'(busy), 0);
        check("cut_done", int'(done), 0);
        @(negedge clk);
        check("cut_done_later", int'(done), 0);
        check("cut_busy_later", int'(busy), 0);
    endtask

    int exp_t2 [7] = '{1, 3, 4, 5, 8, 0, 0};
    int exp_17 [7] = '{1, 2, 3, 4, 5, 6, 7};
    int exp_1  [7] = '{9, 0, 0, 0, 0, 0, 0};

    initial begin
        tree_clear();
        repeat (2) @(negedge clk);
        // Reset state.
        check("reset_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        check("reset_key", int'(out_key), 0);
        check("reset_rd_idx", int'(rd_idx), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: empty tree -> done at cycle 1, nothing emitted, never busy.
        walk(-1, 6);
        check("t1_first_done", first_done, 1);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_valid", int'(saw_valid), 0);
        check("t1_busy", int'(saw_busy), 0);

        // Single node: out_valid at cycle 4, done at cycle 6.
        tree_add(4'd9);
        walk(-1, 12);
        check_seq("one", exp_1, 1);
        check("one_first_valid", first_valid, 4);
        check("one_first_done", first_done, 6);

        // T2: 5,3,8,1,4 with ready held high.
        tree_clear();
        tree_add(4'd5); tree_add(4'd3); tree_add(4'd8); tree_add(4'd1); tree_add(4'd4);
        walk(-1, 60);
        check_seq("t2", exp_t2, 5);
        check("t2_busy_end", int'(busy), 0);

        // T3: same tree, consumer stalls 10 cycles on key 3.
        walk(3, 60);
        check_seq("t3", exp_t2, 5);

        // T4: right chain 1..7, then left chain 7..1 (full stack depth).
        tree_clear();
        for (int k = 1; k <= 7; k++) tree_add(4'(k));
        walk(-1, 80);
        check_seq("t4r", exp_17, 7);
        tree_clear();
        for (int k = 7; k >= 1; k--) tree_add(4'(k));
        walk(-1, 80);
        check_seq("t4l", exp_17, 7);

        // T5: root's left points back to itself -> overflow.
        tree_clear();
        for (int k = 1; k <= 7; k++) tree_add(4'(k));
        left_m[0] = 3'd0;
        walk(-1, 15);
        check("t5_err", int'(err), 1);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_done_by_10", int'(first_done >= 1 && first_done <= 10), 1);
        check("t5_valid", int'(saw_valid), 0);
        repeat (3) @(negedge clk);
        check("t5_err_sticky", int'(err), 1);

        // T6: abort, then reset, mid-walk; a restart gives the full sequence.
        tree_clear();
        tree_add(4'd5); tree_add(4'd3); tree_add(4'd8); tree_add(4'd1); tree_add(4'd4);
        cut_after2(1'b0);
        walk(-1, 60);
        check_seq("t6a", exp_t2, 5);
        cut_after2(1'b1);
        walk(-1, 60);
        check_seq("t6r", exp_t2, 5);

        // Abort beats a same-cycle start.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", int'(busy), 0);
        check("abort_start_done", int'(done), 0);
        @(negedge clk);
        check("abort_start_busy2", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog: ends the run even if a task stalls.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
